// File: rtl/sr_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sr_bank_ctrl
// Description : Round-robin arbitrating controller for a bank of NFLAG
//               external SR latches. Each accepted set/clear command drives
//               one latch pin for PULSE_W cycles, then holds a one-cycle
//               recovery gap. A shadow copy of the latch contents is kept on
//               'flags'. s and r are never high together on any bit.
//               Optional build macro SR_BANK_SKIP_REDUNDANT_EN: a command
//               whose op already matches the shadow bit is accepted without
//               driving any pin.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_bank_ctrl #(
    parameter int NREQ    = 4,
    parameter int NFLAG   = 8,
    parameter int IDXW    = 3,
    parameter int PULSE_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_op,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      req_ready,
    output logic [NFLAG-1:0]     latch_s,
    output logic [NFLAG-1:0]     latch_r,
    output logic [NFLAG-1:0]     flags,
    output logic                 busy,
    output logic                 err_idx
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(PULSE_W - 1);
    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_DRIVE   = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [PTRW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NFLAG-1:0] flags_q, flags_d;
    logic             op_q, op_d;
    logic [IDXW-1:0]  idx_q, idx_d;

    // Arbiter results for the current IDLE cycle
    logic             w_lo_any;
    logic [PTRW-1:0]  w_lo_id;
    logic             w_hi_any;
    logic [PTRW-1:0]  w_hi_id;
    logic [PTRW-1:0]  w_gnt_id;
    logic [PTRW-1:0]  w_gnt_nxt;
    logic [NREQ-1:0]  w_gnt_oh;
    logic             w_gnt_op;
    logic [IDXW-1:0]  w_gnt_idx;
    logic [31:0]      w_gnt_idx_ext;
    logic             w_gnt_oor;
    logic             w_skip;
    logic [NFLAG-1:0] w_drv_mask;

    // Round-robin search: lowest requester at or above rr_ptr wins, otherwise
    // wrap around to the lowest requester overall. Scanning downward lets the
    // last hit (the lowest index) win in each class.
    always_comb begin
        w_lo_any = 1'b0;
        w_lo_id  = '0;
        w_hi_any = 1'b0;
        w_hi_id  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_lo_any = 1'b1;
                w_lo_id  = PTRW'(i);
                if (PTRW'(i) >= rr_ptr_q) begin
                    w_hi_any = 1'b1;
                    w_hi_id  = PTRW'(i);
                end
            end
        end
    end

    assign w_gnt_id  = w_hi_any ? w_hi_id : w_lo_id;
    assign w_gnt_nxt = (w_gnt_id == PTR_LAST) ? '0 : (w_gnt_id + PTRW'(1));
    assign w_gnt_oh  = NREQ'(1) << w_gnt_id;

    // Select the op and target index belonging to the winning requester
    always_comb begin
        w_gnt_op  = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_id == PTRW'(i)) begin
                w_gnt_op  = req_op[i];
                w_gnt_idx = req_idx[i*IDXW +: IDXW];
            end
        end
    end

    // Index range check done at 32 bits so it stays valid for any IDXW/NFLAG pair
    assign w_gnt_idx_ext = {{(32-IDXW){1'b0}}, w_gnt_idx};
    assign w_gnt_oor     = (w_gnt_idx_ext >= NFLAG);

`ifdef SR_BANK_SKIP_REDUNDANT_EN
    logic [NFLAG-1:0] w_gnt_mask;
    assign w_gnt_mask = NFLAG'(1) << w_gnt_idx;
    // Command would leave the latch unchanged: accept it without a pulse
    assign w_skip     = (((flags_q & w_gnt_mask) != '0) == w_gnt_op);
`else
    assign w_skip     = 1'b0;
`endif

    // One-hot of the latch currently being driven (always in range in DRIVE)
    assign w_drv_mask = NFLAG'(1) << idx_q;

    // Next-state and output decode; every output defaults to its quiet value
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_ptr_d  = rr_ptr_q;
        flags_d   = flags_q;
        op_d      = op_q;
        idx_d     = idx_q;
        req_ready = '0;
        latch_s   = '0;
        latch_r   = '0;
        busy      = 1'b1;
        err_idx   = 1'b0;
        case (state_q)
            ST_INIT: begin
                // Hold every reset pin so the bank matches the cleared shadow
                latch_r = '1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RECOVER;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_IDLE: begin
                busy = 1'b0;
                if (w_lo_any) begin
                    req_ready = w_gnt_oh;
                    rr_ptr_d  = w_gnt_nxt;
                    op_d      = w_gnt_op;
                    idx_d     = w_gnt_idx;
                    cnt_d     = '0;
                    if (w_gnt_oor) begin
                        err_idx = 1'b1;
                        state_d = ST_RECOVER;
                    end else if (w_skip) begin
                        state_d = ST_RECOVER;
                    end else begin
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (op_q) begin
                    latch_s = w_drv_mask;
                end else begin
                    latch_r = w_drv_mask;
                end
                if (cnt_q == CNT_LAST) begin
                    flags_d = op_q ? (flags_q | w_drv_mask) : (flags_q & ~w_drv_mask);
                    cnt_d   = '0;
                    state_d = ST_RECOVER;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State registers; reset restarts the bank clear and drops any command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            flags_q  <= '0;
            op_q     <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            flags_q  <= flags_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
        end
    end

    assign flags = flags_q;

endmodule
`default_nettype wire
